// File: rtl/uart_pkg.sv
// Shared UART receive-path types: buffered frame entry and capture FSM states.
package uart_pkg;

    localparam int unsigned UART_DATA_WIDTH = 9;

    typedef struct packed {
        logic                       brk;
        logic                       parity;
        logic [UART_DATA_WIDTH-1:0] data;
    } rx_entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        WAIT = 2'd2
    } rx_fifo_state_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// Register-array FIFO storage with write/read pointers and an asynchronous head read.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      wr_en,
    input  rx_entry_t wr_data,
    input  logic      rd_en,
    output rx_entry_t rd_data
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

    rx_entry_t             mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;

    // Pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            if (rd_en) rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: acks receiver frames into a FWFT FIFO with level/overrun/timeout irq.
// Optional idle timeout enabled by defining UART_RX_FIFO_TIMEOUT_EN.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2    = 4,
    parameter int unsigned TIMEOUT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [UART_DATA_WIDTH-1:0] rxData,
    input  logic                       rxValid,
    input  logic                       rxParityError,
    input  logic                       rxBreak,
    input  logic                       rxOverflow,
    output logic                       rxAck,
    output logic [UART_DATA_WIDTH-1:0] rdData,
    output logic                       rdParityError,
    output logic                       rdBreak,
    output logic                       rdValid,
    input  logic                       rdEn,
    output logic [DEPTH_LOG2:0]        level,
    output logic                       full,
    input  logic [DEPTH_LOG2:0]        threshold,
    input  logic [TIMEOUT_WIDTH-1:0]   timeoutCycles,
    output logic                       overrun,
    input  logic                       clearOverrun,
    output logic                       irq
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam int unsigned LW    = DEPTH_LOG2 + 1;

    rx_fifo_state_t state;
    rx_entry_t      wr_entry;
    rx_entry_t      head;
    logic           pending;
    logic           push;
    logic           pop;
    logic [LW-1:0]  level_next;
    logic           level_irq_next;
    logic           overrun_next;
    logic           timeout_flag;
    logic           timeout_next;

    assign pending = rxValid || rxBreak;
    assign pop     = rdEn && rdValid;
    // A full FIFO can still take a frame when the head leaves in the same cycle.
    assign push    = (state == IDLE) && pending && (!full || pop);

    assign wr_entry = '{brk: rxBreak, parity: rxParityError,
                        data: rxValid ? rxData : '0};

    uart_fifo_mem #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_mem (
        .clk    (clk),
        .rst_n  (rst),
        .wr_en  (push),
        .wr_data(wr_entry),
        .rd_en  (pop),
        .rd_data(head)
    );

    assign rdData        = rdValid ? head.data : '0;
    assign rdParityError = rdValid && head.parity;
    assign rdBreak       = rdValid && head.brk;

    always_comb begin
        level_next = level;
        case ({push, pop})
            2'b10:   level_next = level + LW'(1);
            2'b01:   level_next = level - LW'(1);
            default: level_next = level;
        endcase
    end

    assign level_irq_next = (threshold != '0) && (level_next >= threshold);
    assign overrun_next   = rxOverflow || (overrun && !clearOverrun);

`ifdef UART_RX_FIFO_TIMEOUT_EN
    logic [TIMEOUT_WIDTH-1:0] idle_cnt;
    logic [TIMEOUT_WIDTH-1:0] idle_cnt_next;

    // Idle counter saturates so a stale entry cannot re-trigger after wrap.
    always_comb begin
        idle_cnt_next = '0;
        timeout_next  = timeout_flag;
        if (rdValid && !push && !pop) begin
            idle_cnt_next = (idle_cnt == '1) ? idle_cnt : idle_cnt + TIMEOUT_WIDTH'(1);
        end
        if (pop || (level_next == '0)) begin
            timeout_next = 1'b0;
        end else if ((timeoutCycles != '0) && (idle_cnt_next == timeoutCycles)) begin
            timeout_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) idle_cnt <= '0;
        else      idle_cnt <= idle_cnt_next;
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^timeoutCycles;
    assign timeout_next   = 1'b0;
`endif

    // Capture FSM: accept, pulse ack, then wait for the receiver to drop its levels.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            rxAck <= 1'b0;
        end else begin
            rxAck <= 1'b0;
            case (state)
                IDLE: begin
                    if (push) begin
                        state <= ACK;
                        rxAck <= 1'b1;
                    end
                end
                ACK:     state <= WAIT;
                WAIT: begin
                    if (!rxValid && !rxBreak) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Status registers are loaded from next-state values so irq tracks level in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level        <= '0;
            rdValid      <= 1'b0;
            full         <= 1'b0;
            overrun      <= 1'b0;
            timeout_flag <= 1'b0;
            irq          <= 1'b0;
        end else begin
            level        <= level_next;
            rdValid      <= (level_next != '0);
            full         <= (level_next == LW'(DEPTH));
            overrun      <= overrun_next;
            timeout_flag <= timeout_next;
            irq          <= level_irq_next || timeout_next || overrun_next;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized, self-checking bench for uart_rx_fifo against a queue-based FIFO model.
module tb_uart_rx_fifo;
    import uart_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  rxData;
    logic        rxValid;
    logic        rxParityError;
    logic        rxBreak;
    logic        rxOverflow;
    logic        rxAck;
    logic [8:0]  rdData;
    logic        rdParityError;
    logic        rdBreak;
    logic        rdValid;
    logic        rdEn;
    logic [4:0]  level;
    logic        full;
    logic [4:0]  threshold;
    logic [15:0] timeoutCycles;
    logic        overrun;
    logic        clearOverrun;
    logic        irq;

    int checks = 0;
    int errors = 0;
    logic [10:0] q[$];
    int wr_idx = 0;
    int rd_idx = 0;

    uart_rx_fifo #(.DEPTH_LOG2(4), .TIMEOUT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .rxData(rxData), .rxValid(rxValid),
        .rxParityError(rxParityError), .rxBreak(rxBreak), .rxOverflow(rxOverflow),
        .rxAck(rxAck), .rdData(rdData), .rdParityError(rdParityError), .rdBreak(rdBreak),
        .rdValid(rdValid), .rdEn(rdEn), .level(level), .full(full), .threshold(threshold),
        .timeoutCycles(timeoutCycles), .overrun(overrun), .clearOverrun(clearOverrun), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Receiver model: hold levels until ack, drop at the edge ending the ack cycle.
    task automatic send_frame(input logic [8:0] d, input logic p, input logic b, input logic v,
                              output logic acked, output int waited,
                              output logic [4:0] ack_level, output logic ack_irq);
        rxData = d; rxParityError = p; rxBreak = b; rxValid = v;
        acked = 1'b0; waited = 0; ack_level = '0; ack_irq = 1'b0;
        for (int i = 0; i < 8 && !acked; i++) begin
            tick();
            waited++;
            if (rxAck === 1'b1) begin
                acked = 1'b1; ack_level = level; ack_irq = irq;
            end
        end
        rxValid = 0; rxBreak = 0; rxParityError = 0; rxData = '0;
        tick();
        tick();
        if (acked) begin
            q.push_back({b, p, v ? d : 9'd0});
            wr_idx++;
        end
    endtask

    task automatic pop_one();
        rdEn = 1'b1;
        tick();
        rdEn = 1'b0;
        if (q.size() > 0) begin
            void'(q.pop_front());
            rd_idx++;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 17 && q.size() > 0; i++) pop_one();
    endtask

    task automatic test_reset();
        rst = 1'b0; rxData = '0; rxValid = 0; rxParityError = 0; rxBreak = 0; rxOverflow = 0;
        rdEn = 0; threshold = '0; timeoutCycles = '0; clearOverrun = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({rxAck, rdValid, full, overrun, irq} !== 5'b0)
            $display("FAIL reset_flags got=%b exp=00000", {rxAck, rdValid, full, overrun, irq});
        checks++;
        if (level !== 5'd0 || rdData !== 9'd0)
            $display("FAIL reset_level_data got level=%0d data=%h exp 0/0", level, rdData);
        if ({rxAck, rdValid, full, overrun, irq} !== 5'b0 || level !== 5'd0 || rdData !== 9'd0) errors++;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single();
        rxData = 9'h0A5; rxParityError = 0; rxValid = 1;
        checks++;
        if (rxAck !== 1'b0) begin errors++; $display("FAIL single_early_ack got=%b exp=0", rxAck); end
        tick();
        checks++;
        if (rxAck !== 1'b1 || rdValid !== 1'b1 || level !== 5'd1 || rdData !== 9'h0A5) begin
            errors++;
            $display("FAIL single_capture got ack=%b valid=%b level=%0d data=%h exp 1/1/1/0a5",
                     rxAck, rdValid, level, rdData);
        end
        rxValid = 0; rxData = '0;
        tick();
        checks++;
        if (rxAck !== 1'b0) begin errors++; $display("FAIL single_ack_width got=%b exp=0", rxAck); end
        tick();
        rdEn = 1; tick(); rdEn = 0;
        wr_idx++; rd_idx++;
        checks++;
        if (level !== 5'd0 || rdValid !== 1'b0 || rdData !== 9'd0) begin
            errors++;
            $display("FAIL single_pop got level=%0d valid=%b data=%h exp 0/0/000", level, rdValid, rdData);
        end
    endtask

    task automatic test_fill_overflow();
        logic acked; int waited; logic [4:0] lv; logic ir; logic got_ack;
        logic [10:0] exp;
        threshold = '0;
        for (int i = 0; i < 16; i++) begin
            send_frame(9'($urandom_range(0, 511)), 1'($urandom_range(0, 1)), 1'b0, 1'b1, acked, waited, lv, ir);
            checks++;
            if (!acked || waited != 1 || lv !== 5'(i + 1)) begin
                errors++;
                $display("FAIL fill_ack[%0d] got ack=%b wait=%0d level=%0d exp 1/1/%0d", i, acked, waited, lv, i + 1);
            end
        end
        checks++;
        if (full !== 1'b1 || level !== 5'd16) begin
            errors++; $display("FAIL fill_full got full=%b level=%0d exp 1/16", full, level);
        end
        rxData = 9'h155; rxParityError = 1; rxValid = 1;
        got_ack = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rxAck !== 1'b0) got_ack = 1'b1;
        end
        checks++;
        if (got_ack) begin errors++; $display("FAIL full_no_ack got ack=1 exp=0"); end
        rxOverflow = 1; tick(); rxOverflow = 0;
        checks++;
        if (overrun !== 1'b1 || irq !== 1'b1) begin
            errors++; $display("FAIL overrun_set got ovr=%b irq=%b exp 1/1", overrun, irq);
        end
        exp = q[0];
        rdEn = 1;
        checks++;
        if ({rdBreak, rdParityError, rdData} !== exp) begin
            errors++; $display("FAIL full_head got=%h exp=%h", {rdBreak, rdParityError, rdData}, exp);
        end
        tick();
        rdEn = 0;
        void'(q.pop_front()); rd_idx++;
        q.push_back({1'b0, 1'b1, 9'h155}); wr_idx++;
        checks++;
        if (rxAck !== 1'b1 || level !== 5'd16 || full !== 1'b1) begin
            errors++;
            $display("FAIL pop_push_full got ack=%b level=%0d full=%b exp 1/16/1", rxAck, level, full);
        end
        rxValid = 0; rxParityError = 0; rxData = '0;
        tick(); tick();
        for (int i = 0; i < 16; i++) begin
            exp = q[0];
            checks++;
            if ({rdBreak, rdParityError, rdData} !== exp) begin
                errors++; $display("FAIL drain_order[%0d] got=%h exp=%h", i, {rdBreak, rdParityError, rdData}, exp);
            end
            pop_one();
        end
        checks++;
        if (level !== 5'd0 || irq !== 1'b1) begin
            errors++; $display("FAIL drained got level=%0d irq=%b exp 0/1", level, irq);
        end
        rxOverflow = 1; clearOverrun = 1; tick(); rxOverflow = 0;
        checks++;
        if (overrun !== 1'b1) begin errors++; $display("FAIL set_wins got=%b exp=1", overrun); end
        tick(); clearOverrun = 0;
        checks++;
        if (overrun !== 1'b0 || irq !== 1'b0) begin
            errors++; $display("FAIL overrun_clear got ovr=%b irq=%b exp 0/0", overrun, irq);
        end
    endtask

    task automatic test_break();
        logic acked, acked2; int waited; logic [4:0] lv; logic ir;
        send_frame(9'h1FF, 1'b0, 1'b1, 1'b0, acked, waited, lv, ir);
        send_frame(9'h0AA, 1'b1, 1'b1, 1'b1, acked2, waited, lv, ir);
        checks++;
        if (!acked || !acked2) begin errors++; $display("FAIL break_ack got=%b%b exp=11", acked, acked2); end
        checks++;
        if ({rdBreak, rdParityError, rdData} !== 11'h400) begin
            errors++; $display("FAIL break_entry got=%h exp=400", {rdBreak, rdParityError, rdData});
        end
        pop_one();
        checks++;
        if ({rdBreak, rdParityError, rdData} !== 11'h6AA) begin
            errors++; $display("FAIL break_parity got=%h exp=6aa", {rdBreak, rdParityError, rdData});
        end
        drain();
    endtask

    task automatic test_threshold();
        logic acked; int waited; logic [4:0] lv; logic ir;
        threshold = 5'd4;
        for (int i = 1; i <= 5; i++) begin
            send_frame(9'($urandom_range(0, 511)), 1'b0, 1'b0, 1'b1, acked, waited, lv, ir);
            checks++;
            if (!acked || lv !== 5'(i) || ir !== (i >= 4)) begin
                errors++;
                $display("FAIL thr_rise[%0d] got ack=%b level=%0d irq=%b exp 1/%0d/%0d", i, acked, lv, ir, i, i >= 4);
            end
        end
        pop_one();
        checks++;
        if (level !== 5'd4 || irq !== 1'b1) begin
            errors++; $display("FAIL thr_hold got level=%0d irq=%b exp 4/1", level, irq);
        end
        pop_one();
        checks++;
        if (level !== 5'd3 || irq !== 1'b0) begin
            errors++; $display("FAIL thr_fall got level=%0d irq=%b exp 3/0", level, irq);
        end
        threshold = 5'd0;
        for (int i = 4; i <= 16; i++) begin
            send_frame(9'($urandom_range(0, 511)), 1'b0, 1'b0, 1'b1, acked, waited, lv, ir);
            checks++;
            if (ir !== 1'b0 || irq !== 1'b0) begin
                errors++; $display("FAIL thr_zero[%0d] got irq=%b/%b exp 0", i, ir, irq);
            end
        end
        drain();
    endtask

    task automatic test_wrap();
        logic acked; int waited; logic [4:0] lv; logic ir; logic [8:0] d;
        for (int i = 0; i < 16 && (wr_idx % 16) != 15; i++) begin
            send_frame(9'($urandom_range(0, 511)), 1'b0, 1'b0, 1'b1, acked, waited, lv, ir);
            pop_one();
        end
        send_frame(9'h13C, 1'b0, 1'b0, 1'b1, acked, waited, lv, ir);
        checks++;
        if ((rd_idx % 16) != 15 || level !== 5'd1 || rdData !== 9'h13C) begin
            errors++; $display("FAIL wrap_setup got idx=%0d level=%0d data=%h exp 15/1/13c", rd_idx % 16, level, rdData);
        end
        for (int k = 0; k < 2; k++) begin
            d = 9'($urandom_range(0, 511));
            rxData = d; rxValid = 1; rdEn = 1;
            tick();
            rdEn = 0;
            void'(q.pop_front()); rd_idx++;
            q.push_back({2'b00, d}); wr_idx++;
            checks++;
            if (rxAck !== 1'b1 || level !== 5'd1 || rdData !== d) begin
                errors++;
                $display("FAIL wrap_pushpop[%0d] got ack=%b level=%0d data=%h exp 1/1/%h", k, rxAck, level, rdData, d);
            end
            rxValid = 0; rxData = '0;
            tick(); tick();
        end
        drain();
        checks++;
        if (level !== 5'd0 || rdValid !== 1'b0) begin
            errors++; $display("FAIL wrap_empty got level=%0d valid=%b exp 0/0", level, rdValid);
        end
    endtask

    task automatic test_random();
        logic do_push, do_pop, v, b, p, exp_acc, exp_pop, exp_irq;
        logic [8:0] d;
        logic [10:0] exp_head;
        for (int it = 0; it < 120; it++) begin
            threshold = 5'($urandom_range(0, 16));
            do_push = ($urandom_range(0, 2) != 0);
            do_pop  = ($urandom_range(0, 2) == 0);
            v = ($urandom_range(0, 3) != 0);
            b = !v || ($urandom_range(0, 7) == 0);
            p = 1'($urandom_range(0, 1));
            d = 9'($urandom_range(0, 511));
            exp_acc = do_push && (q.size() < 16 || (do_pop && q.size() > 0));
            exp_pop = do_pop && q.size() > 0;
            rxData = d; rxParityError = p;
            rxValid = do_push && v; rxBreak = do_push && b;
            rdEn = do_pop;
            tick();
            rdEn = 0;
            if (exp_pop) begin void'(q.pop_front()); rd_idx++; end
            if (exp_acc) begin q.push_back({b, p, v ? d : 9'd0}); wr_idx++; end
            exp_head = (q.size() > 0) ? q[0] : 11'd0;
            exp_irq = (threshold != 5'd0) && (q.size() >= int'(threshold));
            checks++;
            if (rxAck !== exp_acc) begin
                errors++; $display("FAIL rnd_ack[%0d] got=%b exp=%b", it, rxAck, exp_acc);
            end
            checks++;
            if (level !== 5'(q.size()) || rdValid !== (q.size() > 0) || full !== (q.size() == 16)) begin
                errors++;
                $display("FAIL rnd_level[%0d] got level=%0d valid=%b full=%b exp level=%0d", it, level, rdValid, full, q.size());
            end
            checks++;
            if ({rdBreak, rdParityError, rdData} !== exp_head) begin
                errors++; $display("FAIL rnd_head[%0d] got=%h exp=%h", it, {rdBreak, rdParityError, rdData}, exp_head);
            end
            checks++;
            if (irq !== exp_irq) begin
                errors++; $display("FAIL rnd_irq[%0d] got=%b exp=%b", it, irq, exp_irq);
            end
            rxValid = 0; rxBreak = 0; rxParityError = 0; rxData = '0;
            tick(); tick();
        end
        threshold = '0;
        drain();
    endtask

    task automatic test_timeout();
        int first;
        threshold = '0; timeoutCycles = 16'd100;
        rxData = 9'h042; rxValid = 1;
        tick();
        checks++;
        if (rxAck !== 1'b1) begin errors++; $display("FAIL tmo_push got ack=%b exp=1", rxAck); end
        q.push_back(11'h042); wr_idx++;
        rxValid = 0; rxData = '0;
        first = -1;
        for (int t = 1; t <= 150; t++) begin
            tick();
            if (irq === 1'b1 && first < 0) first = t;
        end
        checks++;
`ifdef UART_RX_FIFO_TIMEOUT_EN
        if (first < 98 || first > 102) begin
            errors++; $display("FAIL tmo_rise got cycle=%0d exp=100", first);
        end
`else
        if (first != -1) begin
            errors++; $display("FAIL tmo_disabled got irq at cycle=%0d exp never", first);
        end
`endif
        pop_one();
        tick();
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL tmo_clear got irq=%b exp=0", irq); end
        timeoutCycles = '0;
    endtask

    task automatic test_reset_mid();
        logic acked; int waited; logic [4:0] lv; logic ir;
        threshold = 5'd1;
        for (int i = 0; i < 3; i++)
            send_frame(9'($urandom_range(0, 511)), 1'b0, 1'b0, 1'b1, acked, waited, lv, ir);
        rxOverflow = 1; tick(); rxOverflow = 0;
        rxData = 9'h0C3; rxValid = 1;
        #1 rst = 1'b0;
        #1;
        checks++;
        if (level !== 5'd0 || rdValid !== 1'b0 || rdData !== 9'd0 || irq !== 1'b0 || overrun !== 1'b0 || rxAck !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid got level=%0d valid=%b data=%h irq=%b ovr=%b ack=%b exp all 0",
                     level, rdValid, rdData, irq, overrun, rxAck);
        end
        tick(); tick();
        checks++;
        if (rxAck !== 1'b0) begin errors++; $display("FAIL reset_hold_ack got=%b exp=0", rxAck); end
        q.delete();
        rst = 1'b1;
        tick();
        checks++;
        if (rxAck !== 1'b1 || level !== 5'd1 || rdData !== 9'h0C3) begin
            errors++; $display("FAIL reset_recapture got ack=%b level=%0d data=%h exp 1/1/0c3", rxAck, level, rdData);
        end
        rxValid = 0; rxData = '0;
        tick(); tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_overflow();
        test_break();
        test_threshold();
        test_wrap();
        test_random();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
